// File: rtl/color_round_ctrl.sv
// One colour-assignment round: draws a non-black ball colour, NUM_PLATS-1 distractors
// and the slot that carries the ball, using a free-running LFSR with bounded retries.
module color_round_ctrl #(
    parameter int          COLOR_W   = 3,
    parameter int          NUM_PLATS = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           seed_load,
    input  logic [15:0]                    seed_in,
    input  logic                           force_rnd_en,
    input  logic [15:0]                    force_rnd,
    output logic                           busy,
    output logic                           done,
    output logic [COLOR_W-1:0]             ball_color,
    output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors,
    output logic [$clog2(NUM_PLATS)-1:0]   match_slot
);

    localparam int SLOT_W   = $clog2(NUM_PLATS);
    localparam int NUM_DIST = NUM_PLATS - 1;
    localparam int IDX_W    = (NUM_DIST > 1) ? $clog2(NUM_DIST) : 1;
    localparam int TRY_W    = $clog2(MAX_TRIES + 1);
    localparam int NCOL     = (1 << COLOR_W) - 1;

    typedef enum logic [2:0] {IDLE, BALL, PLAT, SLOT, DONE} state_t;

    state_t                            state_reg, state_next;
    logic [15:0]                       lfsr_reg, lfsr_next;
    logic [TRY_W-1:0]                  tries_reg, tries_next;
    logic [IDX_W-1:0]                  idx_reg, idx_next;
    logic [COLOR_W-1:0]                ball_reg, ball_next;
    logic [NUM_DIST-1:0][COLOR_W-1:0]  dist_reg, dist_next;
    logic [COLOR_W-1:0]                ball_color_reg, ball_color_next;
    logic [NUM_PLATS*COLOR_W-1:0]      plat_colors_reg, plat_colors_next;
    logic [SLOT_W-1:0]                 match_slot_reg, match_slot_next;

    logic [15:0]          rnd;
    logic [COLOR_W-1:0]   cand;
    logic [SLOT_W-1:0]    slot_sel;
    logic                 last_try;
    logic                 plat_accept;
    logic [COLOR_W:0]     fb_sum;
    logic [COLOR_W:0]     fb_mod;
    logic [COLOR_W-1:0]   plat_fallback;
    logic [NUM_PLATS*COLOR_W-1:0] plat_assembled;
    logic                 lfsr_fb;
    logic                 unused_rnd_hi;

    assign rnd           = force_rnd_en ? force_rnd : lfsr_reg;
    assign cand          = rnd[COLOR_W-1:0];
    assign slot_sel      = rnd[SLOT_W-1:0];
    assign unused_rnd_hi = ^rnd[15:COLOR_W];
    assign last_try      = (tries_reg == TRY_W'(MAX_TRIES - 1));
    assign plat_accept   = (cand != '0) && (cand != ball_reg);

    // Fallback ((ball+k) mod NCOL)+1: sum stays below 2*NCOL, so one conditional subtract suffices.
    assign fb_sum        = {1'b0, ball_reg} + (COLOR_W+1)'(idx_reg);
    assign fb_mod        = (fb_sum >= (COLOR_W+1)'(NCOL)) ? fb_sum - (COLOR_W+1)'(NCOL) : fb_sum;
    assign plat_fallback = COLOR_W'(fb_mod + (COLOR_W+1)'(1));

    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

    always_comb begin
        if (seed_load) begin
            lfsr_next = (seed_in == 16'd0) ? LFSR_SEED : seed_in;
        end else begin
            lfsr_next = {lfsr_fb, lfsr_reg[15:1]};
        end
    end

    // Ball goes into slot slot_sel; distractors fill the other slots in ascending order.
    generate
        for (genvar gi = 0; gi < NUM_PLATS; gi++) begin : g_slot
            if (gi == 0) begin : g_first
                assign plat_assembled[gi*COLOR_W +: COLOR_W] =
                    (slot_sel == SLOT_W'(gi)) ? ball_reg : dist_reg[gi];
            end else if (gi == NUM_PLATS - 1) begin : g_last
                assign plat_assembled[gi*COLOR_W +: COLOR_W] =
                    (slot_sel == SLOT_W'(gi)) ? ball_reg : dist_reg[gi-1];
            end else begin : g_mid
                assign plat_assembled[gi*COLOR_W +: COLOR_W] =
                    (slot_sel == SLOT_W'(gi)) ? ball_reg :
                    (slot_sel <  SLOT_W'(gi)) ? dist_reg[gi-1] : dist_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        tries_next       = tries_reg;
        idx_next         = idx_reg;
        ball_next        = ball_reg;
        dist_next        = dist_reg;
        ball_color_next  = ball_color_reg;
        plat_colors_next = plat_colors_reg;
        match_slot_next  = match_slot_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BALL;
                    tries_next = '0;
                end
            end
            BALL: begin
                if (cand != '0 || last_try) begin
                    ball_next  = (cand != '0) ? cand : '1;
                    tries_next = '0;
                    idx_next   = '0;
                    state_next = PLAT;
                end else begin
                    tries_next = tries_reg + TRY_W'(1);
                end
            end
            PLAT: begin
                if (plat_accept || last_try) begin
                    dist_next[idx_reg] = plat_accept ? cand : plat_fallback;
                    tries_next         = '0;
                    if (idx_reg == IDX_W'(NUM_DIST - 1)) begin
                        state_next = SLOT;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    tries_next = tries_reg + TRY_W'(1);
                end
            end
            SLOT: begin
                match_slot_next  = slot_sel;
                plat_colors_next = plat_assembled;
                ball_color_next  = ball_reg;
                state_next       = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            lfsr_reg        <= LFSR_SEED;
            tries_reg       <= '0;
            idx_reg         <= '0;
            ball_reg        <= '0;
            dist_reg        <= '0;
            ball_color_reg  <= '0;
            plat_colors_reg <= '0;
            match_slot_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            lfsr_reg        <= lfsr_next;
            tries_reg       <= tries_next;
            idx_reg         <= idx_next;
            ball_reg        <= ball_next;
            dist_reg        <= dist_next;
            ball_color_reg  <= ball_color_next;
            plat_colors_reg <= plat_colors_next;
            match_slot_reg  <= match_slot_next;
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign ball_color  = ball_color_reg;
    assign plat_colors = plat_colors_reg;
    assign match_slot  = match_slot_reg;

endmodule

// File: tb/tb_color_round_ctrl.sv
// Directed and randomized checks for color_round_ctrl: fallbacks, latency, assembly,
// reset abort, ignored starts and seed-load/reset equivalence.
module tb_color_round_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        force_rnd_en;
    logic [15:0] force_rnd;
    logic        busy;
    logic        done;
    logic [2:0]  ball_color;
    logic [11:0] plat_colors;
    logic [1:0]  match_slot;

    int checks = 0;
    int errors = 0;

    logic [15:0] seq [16];
    logic        use_seq;
    logic [31:0] res [2][10];
    int          lat;
    logic        fbusy;
    logic        saw_done;
    logic        slot_ok;
    logic        others_ok;
    logic [2:0]  sc;

    color_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .force_rnd_en (force_rnd_en),
        .force_rnd    (force_rnd),
        .busy         (busy),
        .done         (done),
        .ball_color   (ball_color),
        .plat_colors  (plat_colors),
        .match_slot   (match_slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency is reported in the spec's cycle count: done visible at the k-th negedge after the start edge.
    task automatic do_round(input int extra_at, output int lat_o, output logic first_busy);
        int step = 0;
        lat_o = 0;
        first_busy = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (use_seq) force_rnd = seq[0];
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) first_busy = busy;
            if (done) begin
                lat_o = k;
                break;
            end
            @(posedge clk);
            #1;
            step++;
            if (use_seq && step < 16) force_rnd = seq[step];
            start = (k == extra_at);
        end
        check("round_timeout", (lat_o != 0), 1);
        @(negedge clk);
        check("done_width", done, 0);
    endtask

    task automatic run_ten(input int which);
        int l;
        logic fb;
        for (int r = 0; r < 10; r++) begin
            repeat (2) @(negedge clk);
            do_round(0, l, fb);
            res[which][r] = {l[7:0], 7'b0, match_slot, plat_colors, ball_color};
            $display("seedrun %0d round %0d: lat=%0d ball=%0d plat=%03h slot=%0d",
                     which, r, l, ball_color, plat_colors, match_slot);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = 16'd0;
        force_rnd_en = 1'b0; force_rnd = 16'd0; use_seq = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("idle_busy", busy, 0);
        check("idle_no_done", saw_done, 0);
        check("idle_ball", ball_color, 0);
        check("idle_plat", plat_colors, 0);
        check("idle_slot", match_slot, 0);
        $display("reset/idle: busy=%0d ball=%0d plat=%03h slot=%0d", busy, ball_color, plat_colors, match_slot);

        // All draws fall back: ball 7, distractors 1,2,3, slot 0.
        force_rnd_en = 1'b1;
        force_rnd = 16'h0000;
        do_round(0, lat, fbusy);
        $display("force0: lat=%0d ball=%0d plat=%03h slot=%0d", lat, ball_color, plat_colors, match_slot);
        check("f0_busy", fbusy, 1);
        check("f0_lat", lat, 34);
        check("f0_ball", ball_color, 7);
        check("f0_slot", match_slot, 0);
        check("f0_plat", plat_colors, 12'h68F);

        // Ball 5 first try, distractors fall back to 6,7,1; extra start mid-round ignored.
        force_rnd = 16'h0005;
        do_round(10, lat, fbusy);
        $display("force5: lat=%0d ball=%0d plat=%03h slot=%0d", lat, ball_color, plat_colors, match_slot);
        check("f5_lat", lat, 27);
        check("f5_ball", ball_color, 5);
        check("f5_slot", match_slot, 1);
        check("f5_plat", plat_colors, 12'h3EE);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) saw_done = 1'b1;
        end
        check("no_queued_start", saw_done, 0);

        // Ball 3, distractors fall back to 4,5,6, slot 3.
        force_rnd = 16'h0003;
        do_round(0, lat, fbusy);
        $display("force3: lat=%0d ball=%0d plat=%03h slot=%0d", lat, ball_color, plat_colors, match_slot);
        check("f3_lat", lat, 27);
        check("f3_ball", ball_color, 3);
        check("f3_slot", match_slot, 3);
        check("f3_plat", plat_colors, 12'h7AC);

        // Per-cycle sequence: ball rej,rej,2; plat0 rej(=ball),4; plat1 7; plat2 rej,1; slot 2.
        for (int i = 0; i < 16; i++) seq[i] = 16'hFFF8;
        seq[2] = 16'hFFFA; seq[3] = 16'hFFFA; seq[4] = 16'hFFFC; seq[5] = 16'hFFFF;
        seq[6] = 16'hFFF8; seq[7] = 16'hFFF9; seq[8] = 16'hFFFE;
        use_seq = 1'b1;
        do_round(0, lat, fbusy);
        use_seq = 1'b0;
        $display("seq: lat=%0d ball=%0d plat=%03h slot=%0d", lat, ball_color, plat_colors, match_slot);
        check("seq_lat", lat, 10);
        check("seq_ball", ball_color, 2);
        check("seq_slot", match_slot, 2);
        check("seq_plat", plat_colors, 12'h2BC);

        // Reset during PLAT aborts the round without a done pulse.
        force_rnd = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ball", ball_color, 0);
        check("abort_plat", plat_colors, 0);
        check("abort_slot", match_slot, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        do_round(0, lat, fbusy);
        $display("after abort: lat=%0d ball=%0d plat=%03h slot=%0d", lat, ball_color, plat_colors, match_slot);
        check("post_lat", lat, 27);
        check("post_plat", plat_colors, 12'h3EE);

        // Free-running LFSR with random seeds.
        force_rnd_en = 1'b0;
        for (int r = 0; r < 1000; r++) begin
            @(negedge clk);
            seed_load = 1'b1;
            seed_in = 16'($urandom);
            @(negedge clk);
            seed_load = 1'b0;
            do_round(0, lat, fbusy);
            slot_ok = 1'b0;
            others_ok = 1'b1;
            for (int s = 0; s < 4; s++) begin
                sc = plat_colors[s*3 +: 3];
                if (s == int'(match_slot)) slot_ok = (sc == ball_color);
                else if (sc == 3'd0 || sc == ball_color) others_ok = 1'b0;
            end
            if (r % 100 == 0)
                $display("rand round %0d: lat=%0d ball=%0d plat=%03h slot=%0d", r, lat, ball_color, plat_colors, match_slot);
            check("rand_lat", (lat >= 6 && lat <= 34), 1);
            check("rand_ball", (ball_color != 3'd0), 1);
            check("rand_slot", slot_ok, 1);
            check("rand_others", others_ok, 1);
        end

        // Reset and seed_load of 0 must yield identical round sequences.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_ten(0);
        @(negedge clk);
        seed_load = 1'b1;
        seed_in = 16'd0;
        @(negedge clk);
        seed_load = 1'b0;
        run_ten(1);
        for (int r = 0; r < 10; r++) begin
            check("seed_equiv", res[1][r], res[0][r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
